// File: rtl/bitcoin_mem_responder.sv
// Word memory responder for the hashing engines: 1-cycle registered reads, engine writes,
// host preload port, and a FIFO log of every engine write.
module bitcoin_mem_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LOG_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        load_valid,
    input  logic [15:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        log_valid,
    output logic [15:0] log_addr,
    output logic [31:0] log_data,
    input  logic        log_ready,
    output logic        log_overflow,
    output logic [7:0]  err_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(LOG_DEPTH);
    localparam int unsigned CW = LW + 1;

    logic [31:0] mem_q [DEPTH];
    logic [15:0] log_addr_mem [LOG_DEPTH];
    logic [31:0] log_data_mem [LOG_DEPTH];

    logic [31:0]   rd_q, rd_d;
    logic [7:0]    err_q, err_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [15:0] eng_idx, load_idx;
    logic        eng_in_range, load_in_range, load_fire;
    logic        full, pop, push_ok;

    always_comb begin
        eng_idx       = mem_addr - BASE_ADDR;
        load_idx      = load_addr - BASE_ADDR;
        eng_in_range  = 32'(eng_idx) < DEPTH;
        load_in_range = 32'(load_idx) < DEPTH;
        load_ready    = !mem_we;
        load_fire     = load_valid && load_ready && load_in_range;

        log_valid = (cnt_q != '0);
        full      = (cnt_q == CW'(LOG_DEPTH));
        pop       = log_valid && log_ready;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        push_ok   = mem_we && (!full || pop);

        rd_d  = eng_in_range ? mem_q[eng_idx[AW-1:0]] : 32'hDEADBEEF;
        err_d = (!eng_in_range && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        ovf_d = ovf_q | (mem_we && full && !pop);

        wr_ptr_d = push_ok ? wr_ptr_q + LW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + LW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end

        mem_read_data = rd_q;
        err_count     = err_q;
        log_overflow  = ovf_q;
        log_addr      = log_valid ? log_addr_mem[rd_ptr_q] : 16'h0000;
        log_data      = log_valid ? log_data_mem[rd_ptr_q] : 32'h0000_0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q     <= 32'h0000_0000;
            err_q    <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // The array keeps its contents across reset; reset only blocks the write on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
        end else if (mem_we && eng_in_range) begin
            mem_q[eng_idx[AW-1:0]] <= mem_write_data;
        end else if (load_fire) begin
            mem_q[load_idx[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_addr_mem[wr_ptr_q] <= mem_addr;
            log_data_mem[wr_ptr_q] <= mem_write_data;
        end
    end

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Directed self-checking bench for bitcoin_mem_responder (BASE_ADDR=0x0100, DEPTH=256,
// LOG_DEPTH=16).
module tb_bitcoin_mem_responder;

    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        load_valid;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        log_valid;
    logic [15:0] log_addr;
    logic [31:0] log_data;
    logic        log_ready;
    logic        log_overflow;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    bitcoin_mem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH    (256),
        .LOG_DEPTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .load_valid    (load_valid),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .log_valid     (log_valid),
        .log_addr      (log_addr),
        .log_data      (log_data),
        .log_ready     (log_ready),
        .log_overflow  (log_overflow),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        mem_we         = 1'b0;
        mem_addr       = BASE;
        mem_write_data = 32'h0;
        load_valid     = 1'b0;
        load_addr      = BASE;
        load_data      = 32'h0;
        log_ready      = 1'b0;
        #12;
        check("rst_rd", mem_read_data, 32'h0);
        check("rst_log_valid", 32'(log_valid), 32'h0);
        check("rst_log_addr", 32'(log_addr), 32'h0);
        check("rst_log_data", log_data, 32'h0);
        check("rst_ovf", 32'(log_overflow), 32'h0);
        check("rst_err", 32'(err_count), 32'h0);
        reset = 1'b0;
        tick();

        // Preload 20 words then stream them back with one-cycle latency.
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_addr  = BASE + 16'(i);
            load_data  = i * 32'h0101_0101;
            #1;
            check("preload_ready", 32'(load_ready), 32'h1);
            tick();
        end
        load_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_addr = BASE + 16'(i);
            tick();
            check($sformatf("readback_%0d", i), mem_read_data, i * 32'h0101_0101);
        end

        // Engine write beats a pending preload to the same word.
        load_valid     = 1'b1;
        load_addr      = BASE + 16'd5;
        load_data      = 32'hAAAA_0000;
        mem_we         = 1'b1;
        mem_addr       = BASE + 16'd5;
        mem_write_data = 32'h1234_5678;
        #1;
        check("conflict_ready0", 32'(load_ready), 32'h0);
        tick();
        check("conflict_readfirst", mem_read_data, 32'h0505_0505);
        check("conflict_log_valid", 32'(log_valid), 32'h1);
        check("conflict_log_addr", 32'(log_addr), 32'(BASE + 16'd5));
        check("conflict_log_data", log_data, 32'h1234_5678);
        mem_we = 1'b0;
        #1;
        check("conflict_ready1", 32'(load_ready), 32'h1);
        tick();
        check("conflict_engine_word", mem_read_data, 32'h1234_5678);
        load_valid = 1'b0;
        tick();
        check("conflict_preload_word", mem_read_data, 32'hAAAA_0000);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check("conflict_log_popped", 32'(log_valid), 32'h0);

        // Read-first collision on addr 7.
        load_valid = 1'b1;
        load_addr  = BASE + 16'd7;
        load_data  = 32'h1;
        tick();
        load_valid     = 1'b0;
        mem_we         = 1'b1;
        mem_addr       = BASE + 16'd7;
        mem_write_data = 32'h2;
        tick();
        check("collide_old", mem_read_data, 32'h1);
        mem_we = 1'b0;
        tick();
        check("collide_new", mem_read_data, 32'h2);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check("collide_log_popped", 32'(log_valid), 32'h0);

        // Fill to 16, then push and pop together while full: no overflow, still 16 deep.
        for (int i = 0; i < 16; i++) begin
            mem_we         = 1'b1;
            mem_addr       = BASE + 16'h40 + 16'(i);
            mem_write_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        mem_addr       = BASE + 16'h50;
        mem_write_data = 32'hB000_0010;
        log_ready      = 1'b1;
        tick();
        mem_we    = 1'b0;
        log_ready = 1'b0;
        mem_addr  = BASE;
        check("fullpp_ovf", 32'(log_overflow), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            check("fullpp_valid", 32'(log_valid), 32'h1);
            check($sformatf("fullpp_addr_%0d", i), 32'(log_addr), 32'(BASE + 16'h40 + 16'(i)));
            check($sformatf("fullpp_data_%0d", i), log_data, 32'hB000_0000 + 32'(i));
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        check("fullpp_empty", 32'(log_valid), 32'h0);

        // 17 writes into a 16-entry log with no pops.
        for (int i = 0; i < 17; i++) begin
            mem_we         = 1'b1;
            mem_addr       = BASE + 16'h20 + 16'(i);
            mem_write_data = 32'hC0DE_0000 + 32'(i);
            tick();
            if (i == 15) check("ovf_before", 32'(log_overflow), 32'h0);
        end
        mem_we = 1'b0;
        check("ovf_after", 32'(log_overflow), 32'h1);
        for (int i = 0; i < 17; i++) begin
            mem_addr = BASE + 16'h20 + 16'(i);
            tick();
            check($sformatf("ovf_word_%0d", i), mem_read_data, 32'hC0DE_0000 + 32'(i));
        end
        mem_addr = BASE;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_addr_%0d", i), 32'(log_addr), 32'(BASE + 16'h20 + 16'(i)));
            check($sformatf("drain_data_%0d", i), log_data, 32'hC0DE_0000 + 32'(i));
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        check("drain_empty", 32'(log_valid), 32'h0);

        // Empty FIFO: push with log_ready high is not popped.
        mem_we         = 1'b1;
        mem_addr       = BASE + 16'h60;
        mem_write_data = 32'h6060_6060;
        log_ready      = 1'b1;
        tick();
        mem_we    = 1'b0;
        log_ready = 1'b0;
        mem_addr  = BASE;
        check("empty_push_valid", 32'(log_valid), 32'h1);
        check("empty_push_data", log_data, 32'h6060_6060);

        // Out-of-range read.
        check("err_before", 32'(err_count), 32'h0);
        mem_addr = 16'h0050;
        tick();
        mem_addr = BASE;
        check("oor_rd", mem_read_data, 32'hDEAD_BEEF);
        check("oor_err", 32'(err_count), 32'h1);

        // Mid-stream reset with a write on the reset edge.
        mem_we         = 1'b1;
        mem_addr       = BASE + 16'd1;
        mem_write_data = 32'hFFFF_FFFF;
        reset          = 1'b1;
        #1;
        check("midrst_err", 32'(err_count), 32'h0);
        check("midrst_log_valid", 32'(log_valid), 32'h0);
        check("midrst_ovf", 32'(log_overflow), 32'h0);
        check("midrst_rd", mem_read_data, 32'h0);
        tick();
        reset  = 1'b0;
        mem_we = 1'b0;
        tick();
        check("midrst_kept", mem_read_data, 32'h0101_0101);
        check("midrst_log_still_empty", 32'(log_valid), 32'h0);

        // err_count saturation.
        mem_addr = 16'h0050;
        for (int i = 0; i < 260; i++) tick();
        mem_addr = BASE;
        check("err_sat", 32'(err_count), 32'hFF);
        tick();
        check("err_sat_hold", 32'(err_count), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitcoin_mem_responder.md
# bitcoin_mem_responder

Memory-side responder for the hashing engines' single-port word memory interface (`mem_we`, `mem_addr`, `mem_write_data`, `mem_read_data`). It serves reads with a fixed one-cycle latency, commits writes, and lets a host preload the array through a separate handshake port. Every committed engine write is recorded in a write-log FIFO, so the bench or host can drain output hashes without scanning memory. It sits opposite `bitcoin_hash` and the SHA-256 blocks in both simulation and the FPGA top level.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000: word address mapped to array index 0.
- `DEPTH`, 256: number of 32-bit words; power of two, at most 65536.
- `LOG_DEPTH`, 16: write-log FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: single clock. The engine's `mem_clk` is tied to this clock at the top level.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_we`  in  1: engine write enable.
- `mem_addr`  in  16: engine word address.
- `mem_write_data`  in  32: engine write data.
- `mem_read_data`  out  32: registered read data.
- `load_valid`  in  1: host preload request.
- `load_addr`  in  16: host preload word address.
- `load_data`  in  32: host preload data.
- `load_ready`  out  1: preload accepted this cycle.
- `log_valid`  out  1: write-log head entry present.
- `log_addr`  out  16: head entry address.
- `log_data`  out  32: head entry data.
- `log_ready`  in  1: host pops the head entry.
- `log_overflow`  out  1: sticky flag, a log entry was dropped.
- `err_count`  out  8: saturating count of out-of-range engine accesses.

## Operation
- Index is `addr - BASE_ADDR`, computed modulo 2^16. An access is in range when the index is less than `DEPTH`.
- The array is not cleared by reset. Contents survive reset.
- Engine read: every cycle `mem_we`=0 samples `mem_addr`. On the next cycle `mem_read_data` shows the array word, or 32'hDEADBEEF if the address is out of range.
- Engine write (`mem_we`=1), in range: the array word is updated at the edge.
- Read/write collision is read-first. When `mem_we`=1, `mem_read_data` shows the pre-write contents of `mem_addr` on the next cycle.
- Engine write, out of range: the array is unchanged and `err_count` increments. The entry is still logged.
- Out-of-range read: `err_count` increments. `err_count` saturates at 255.
- Preload: `load_ready` = `!mem_we` (combinational). A preload transfer happens when `load_valid && load_ready` and writes the array if in range. Out-of-range preloads are silently dropped, are not counted, and are never logged. The engine always wins the single write port.
- Write log: each engine write with `mem_we`=1 pushes {`mem_addr`, `mem_write_data`}.
  - A pop happens when `log_valid && log_ready`.
  - Pointers wrap modulo `LOG_DEPTH`. The occupancy counter runs 0..`LOG_DEPTH`.
  - Full and push with no pop: the entry is dropped, the array write still commits, and `log_overflow` is set until reset.
  - Full, with push and pop in the same cycle: both occur and occupancy stays full.
  - Empty, with push and `log_ready` in the same cycle: the push is accepted and no pop happens. `log_valid` rises on the next cycle.
- `log_addr`/`log_data` are valid only while `log_valid`=1.

## Timing
- Reset values: `mem_read_data`=0, `log_valid`=0, `log_addr`=0, `log_data`=0, `log_overflow`=0, `err_count`=0. FIFO pointers and occupancy are cleared.
- `load_ready` follows `mem_we` with no reset dependence.
- Read latency is exactly 1 cycle. Back-to-back reads on consecutive addresses return data on consecutive cycles, with no bubbles.
- Write latency: a read of the same address issued on the cycle after the write returns the new data.
- Log latency: a pushed entry is visible at the FIFO head 1 cycle after the write edge, provided the FIFO was empty.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - Any write or preload on that edge is not committed.
  - Log contents are discarded.
  - The array keeps its prior words.

## Test plan
- Preload, then read-back: preload words 0x00..0x13 with value `addr*0x01010101` via the host port, then drive 20 consecutive reads from address 0. Each `mem_read_data` appears exactly 1 cycle after its address, with no gaps.
- Engine/preload conflict: hold `load_valid`=1 (addr 5, data 0xAAAA0000) while the engine writes addr 5 with 0x12345678. `load_ready` must be 0 on that cycle. Next cycle: preload accepted, and addr 5 reads 0xAAAA0000.
- Read-first collision: addr 7 holds 0x1. Write 0x2 to addr 7 with `mem_we`=1. `mem_read_data` shows 0x1, and the following read returns 0x2.
- Log fill and overflow: with `log_ready`=0, issue 17 writes with `LOG_DEPTH`=16.
  - `log_overflow` rises after the 17th write.
  - Draining yields 16 entries in order, addresses ascending.
  - All 17 array words are updated.
- Full-FIFO push with pop: with the FIFO full, write and pop in the same cycle. Occupancy stays 16 and `log_overflow` stays 0 from reset.
- Out of range and reset: set `BASE_ADDR`=16'h0100 and read 16'h0050. The response is 0xDEADBEEF and `err_count`=1. Then pulse `reset` mid-stream: `err_count`=0, `log_valid`=0, and a previously preloaded word still reads back unchanged.
